// File: rtl/csr_timer.sv
// ---------------------------------------------------------------------------
// csr_timer
//
// CSR-bus slave timer. It provides one 32-bit up-counter with a compare
// match, optional auto-reload, a sticky pending flag and a level interrupt.
// csr_do is driven to zero whenever the block is not selected, so it can be
// OR-combined with the read data of other slaves.
//
// Register map (index = csr_a[2:0], page = csr_a[13:10]):
//   0 CTRL     bit0 EN, bit1 AUTORELOAD, bit2 IRQEN
//   1 COMPARE
//   2 COUNTER  (read/write)
//   3 STATUS   bit0 PENDING, write 1 to clear
//   4 PRESCALE (only with TIMER_PRESCALE_EN, otherwise reads 0)
//   5-7        reserved, read 0
//
// Optional feature macro: TIMER_PRESCALE_EN
//   When defined, a PRESCALE register and a tick divider are added, and the
//   counter advances once every PRESCALE+1 cycles. When undefined, the
//   counter advances every cycle and no divider logic exists.
//
// Ports:
//   sys_clk  in   1   system clock
//   sys_rst  in   1   asynchronous active-high reset
//   csr_a    in  14   CSR word address
//   csr_we   in   1   CSR write strobe
//   csr_di   in  32   CSR write data
//   csr_do   out 32   CSR read data, registered (one cycle after address)
//   irq      out  1   level interrupt, PENDING & IRQEN
// ---------------------------------------------------------------------------
module csr_timer #(
    parameter logic [3:0]  csr_addr       = 4'h2,
    parameter logic [31:0] PRESCALE_RESET = 32'd0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq
);

    logic        sel;
    logic        wr;
    logic [2:0]  idx;

    logic        wr_ctrl;
    logic        wr_compare;
    logic        wr_counter;
    logic        wr_status;

    logic        ctrl_en;
    logic        ctrl_autoreload;
    logic        ctrl_irqen;
    logic [31:0] compare;
    logic [31:0] counter;
    logic        pending;

    logic        tick;
    logic        match;
    logic        match_taken;
    logic [31:0] prescale_rd;
    logic [31:0] rd_data;

    // Address bits between the page select and the register index are
    // don't-care; they alias the same registers.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^csr_a[9:3];

    assign sel = (csr_a[13:10] == csr_addr);
    assign idx = csr_a[2:0];
    assign wr  = sel & csr_we;

    assign wr_ctrl    = wr && (idx == 3'd0);
    assign wr_compare = wr && (idx == 3'd1);
    assign wr_counter = wr && (idx == 3'd2);
    assign wr_status  = wr && (idx == 3'd3);

`ifdef TIMER_PRESCALE_EN
    logic        wr_prescale;
    logic [31:0] prescale;
    logic [31:0] div_count;

    assign wr_prescale = wr && (idx == 3'd4);

    // Prescale register, reloaded from the parameterised reset value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            prescale <= PRESCALE_RESET;
        end else if (wr_prescale) begin
            prescale <= csr_di;
        end
    end

    // Divider restarts from zero whenever the timer is stopped or the
    // divide ratio changes, so the first tick after enabling is always a
    // full PRESCALE+1 cycles away.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_count <= 32'd0;
        end else if (!ctrl_en || wr_prescale) begin
            div_count <= 32'd0;
        end else if (div_count == prescale) begin
            div_count <= 32'd0;
        end else begin
            div_count <= div_count + 32'd1;
        end
    end

    assign tick        = ctrl_en && (div_count == prescale);
    assign prescale_rd = prescale;
`else
    logic unused_prescale_reset;
    assign unused_prescale_reset = ^PRESCALE_RESET;

    assign tick        = 1'b1;
    assign prescale_rd = 32'd0;
`endif

    // A match only counts when no firmware write to COUNTER or CTRL lands in
    // the same cycle; firmware always wins that race.
    assign match       = ctrl_en && tick && (counter == compare);
    assign match_taken = match && !wr_ctrl && !wr_counter;

    // Control bits. A one-shot match stops the timer by clearing EN.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ctrl_en         <= 1'b0;
            ctrl_autoreload <= 1'b0;
            ctrl_irqen      <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en         <= csr_di[0];
            ctrl_autoreload <= csr_di[1];
            ctrl_irqen      <= csr_di[2];
        end else if (match_taken && !ctrl_autoreload) begin
            ctrl_en         <= 1'b0;
        end
    end

    // Compare register. A write in a match cycle does not affect that
    // cycle's comparison, which already used the old value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            compare <= 32'hFFFF_FFFF;
        end else if (wr_compare) begin
            compare <= csr_di;
        end
    end

    // Counter. On a match it either reloads to zero or holds; on a match
    // discarded by a CTRL write it holds. Otherwise it wraps silently.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            counter <= 32'd0;
        end else if (wr_counter) begin
            counter <= csr_di;
        end else if (ctrl_en && tick) begin
            if (counter == compare) begin
                if (match_taken && ctrl_autoreload) begin
                    counter <= 32'd0;
                end
            end else begin
                counter <= counter + 32'd1;
            end
        end
    end

    // Sticky pending flag. A new match beats a simultaneous W1C.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pending <= 1'b0;
        end else if (match_taken) begin
            pending <= 1'b1;
        end else if (wr_status && csr_di[0]) begin
            pending <= 1'b0;
        end
    end

    // Read multiplexer over the current register contents.
    always_comb begin
        rd_data = 32'd0;
        case (idx)
            3'd0:    rd_data = {29'd0, ctrl_irqen, ctrl_autoreload, ctrl_en};
            3'd1:    rd_data = compare;
            3'd2:    rd_data = counter;
            3'd3:    rd_data = {31'd0, pending};
            3'd4:    rd_data = prescale_rd;
            default: rd_data = 32'd0;
        endcase
    end

    // Registered read data; zero when another page is addressed so the bus
    // OR-combine sees nothing from this block.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            csr_do <= 32'd0;
        end else if (sel) begin
            csr_do <= rd_data;
        end else begin
            csr_do <= 32'd0;
        end
    end

    assign irq = pending & ctrl_irqen;

endmodule

// File: tb/tb_csr_timer.sv
// ---------------------------------------------------------------------------
// tb_csr_timer
//
// Directed self-checking bench for csr_timer. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active
// rising edge. Each scenario task does its own comparisons.
// ---------------------------------------------------------------------------
module tb_csr_timer;

    localparam logic [3:0] PAGE = 4'h2;

    logic        sys_clk;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;

    int vectors;
    int miscompares;

    csr_timer #(
        .csr_addr       (PAGE),
        .PRESCALE_RESET (32'd0)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_di  (csr_di),
        .csr_do  (csr_do),
        .irq     (irq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [13:0] addr_of(input logic [3:0] page, input logic [2:0] idx);
        return {page, 7'd0, idx};
    endfunction

    // Entered and left on a falling edge; the write lands on the rising edge
    // in between.
    task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
        csr_a  = addr_of(PAGE, idx);
        csr_di = data;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_di = 32'd0;
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [31:0] data);
        csr_a  = addr_of(PAGE, idx);
        csr_we = 1'b0;
        @(negedge sys_clk);
        data = csr_do;
    endtask

    task automatic do_reset;
        sys_rst = 1'b1;
        csr_we  = 1'b0;
        csr_a   = 14'd0;
        csr_di  = 32'd0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [31:0] exp_rst [8];
        exp_rst = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), d);
            vectors++;
            if (d !== exp_rst[i]) begin
                miscompares++;
                $display("[TB] FAIL reset_read idx%0d: got %h, expected %h", i, d, exp_rst[i]);
            end
        end
        csr_a = addr_of(4'h3, 3'd1);
        @(negedge sys_clk);
        vectors++;
        if (csr_do !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL unselected_read: got %h, expected %h", csr_do, 32'd0);
        end
        csr_a = addr_of(PAGE, 3'd1);
        #1;
        vectors++;
        if (csr_do !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL read_before_edge: got %h, expected %h", csr_do, 32'd0);
        end
        @(posedge sys_clk);
        #1;
        vectors++;
        if (csr_do !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL read_after_edge: got %h, expected %h", csr_do, 32'hFFFF_FFFF);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        do_reset();
        bus_write(3'd1, 32'd10);
        bus_write(3'd0, 32'd5);
        csr_a = addr_of(PAGE, 3'd7);
        repeat (10) @(negedge sys_clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL oneshot_irq_early: got %b, expected 0", irq);
        end
        @(negedge sys_clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL oneshot_irq_rise: got %b, expected 1", irq);
        end
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL oneshot_status: got %h, expected %h", d, 32'd1);
        end
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL oneshot_ctrl: got %h, expected %h", d, 32'd4);
        end
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'd10) begin
            miscompares++;
            $display("[TB] FAIL oneshot_counter: got %h, expected %h", d, 32'd10);
        end
    endtask

    task automatic test_autoreload;
        logic [31:0] exp_cnt;
        logic        exp_irq;
        do_reset();
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'd7);
        csr_a = addr_of(PAGE, 3'd2);
        for (int k = 2; k <= 10; k++) begin
            @(negedge sys_clk);
            exp_cnt = 32'((k - 2) % 4);
            exp_irq = (k >= 5);
            vectors++;
            if (csr_do !== exp_cnt) begin
                miscompares++;
                $display("[TB] FAIL reload_counter step%0d: got %h, expected %h", k, csr_do, exp_cnt);
            end
            vectors++;
            if (irq !== exp_irq) begin
                miscompares++;
                $display("[TB] FAIL reload_irq step%0d: got %b, expected %b", k, irq, exp_irq);
            end
        end
        bus_write(3'd3, 32'd1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reload_w1c: got %b, expected 0", irq);
        end
        @(negedge sys_clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reload_w1c_hold: got %b, expected 0", irq);
        end
        @(negedge sys_clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reload_reassert: got %b, expected 1", irq);
        end
    endtask

    task automatic test_collisions;
        logic [31:0] d;
        do_reset();
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'd3);
        csr_a = addr_of(PAGE, 3'd7);
        repeat (3) @(negedge sys_clk);
        bus_write(3'd2, 32'd100);
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'd100) begin
            miscompares++;
            $display("[TB] FAIL collide_counter_value: got %h, expected %h", d, 32'd100);
        end
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL collide_counter_pending: got %h, expected %h", d, 32'd0);
        end

        do_reset();
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'd3);
        csr_a = addr_of(PAGE, 3'd7);
        repeat (3) @(negedge sys_clk);
        bus_write(3'd3, 32'd1);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL collide_w1c_pending: got %h, expected %h", d, 32'd1);
        end

        do_reset();
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'd1);
        csr_a = addr_of(PAGE, 3'd7);
        repeat (3) @(negedge sys_clk);
        bus_write(3'd1, 32'd50);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL collide_compare_pending: got %h, expected %h", d, 32'd1);
        end
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL collide_compare_ctrl: got %h, expected %h", d, 32'd0);
        end
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL collide_compare_counter: got %h, expected %h", d, 32'd3);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_cnt [8];
        logic        exp_irq;
        exp_cnt = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        do_reset();
        bus_write(3'd2, 32'hFFFF_FFFE);
        bus_write(3'd1, 32'd5);
        bus_write(3'd0, 32'd5);
        csr_a = addr_of(PAGE, 3'd2);
        for (int k = 2; k <= 9; k++) begin
            @(negedge sys_clk);
            exp_irq = (k >= 9);
            vectors++;
            if (csr_do !== exp_cnt[k - 2]) begin
                miscompares++;
                $display("[TB] FAIL wrap_counter step%0d: got %h, expected %h", k, csr_do, exp_cnt[k - 2]);
            end
            vectors++;
            if (irq !== exp_irq) begin
                miscompares++;
                $display("[TB] FAIL wrap_irq step%0d: got %b, expected %b", k, irq, exp_irq);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        do_reset();
        bus_write(3'd1, 32'd2);
        bus_write(3'd0, 32'd5);
        csr_a = addr_of(PAGE, 3'd1);
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL arst_pre_irq: got %b, expected 1", irq);
        end
        vectors++;
        if (csr_do !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL arst_pre_do: got %h, expected %h", csr_do, 32'd2);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        vectors++;
        if (csr_do !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL arst_do: got %h, expected %h", csr_do, 32'd0);
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL arst_irq: got %b, expected 0", irq);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL arst_ctrl: got %h, expected %h", d, 32'd0);
        end
        bus_read(3'd2, d);
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL arst_counter_idle: got %h, expected %h", d, 32'd0);
        end
        bus_read(3'd1, d);
        vectors++;
        if (d !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL arst_compare: got %h, expected %h", d, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_prescale;
        logic [31:0] d;
        do_reset();
`ifdef TIMER_PRESCALE_EN
        bus_write(3'd4, 32'd2);
        bus_write(3'd1, 32'd4);
        bus_write(3'd0, 32'd5);
        csr_a = addr_of(PAGE, 3'd7);
        repeat (14) @(negedge sys_clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL prescale_irq_early: got %b, expected 0", irq);
        end
        @(negedge sys_clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL prescale_irq_rise: got %b, expected 1", irq);
        end
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL prescale_counter: got %h, expected %h", d, 32'd4);
        end
        bus_read(3'd4, d);
        vectors++;
        if (d !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL prescale_readback: got %h, expected %h", d, 32'd2);
        end
`else
        bus_write(3'd4, 32'd7);
        bus_read(3'd4, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL prescale_absent: got %h, expected %h", d, 32'd0);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sys_rst     = 1'b1;
        csr_a       = 14'd0;
        csr_we      = 1'b0;
        csr_di      = 32'd0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_collisions();
        test_wrap();
        test_async_reset();
        test_prescale();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
